truth_table_scanner: RTL and testbench

- Sequential, width-parametrised successor to the hand-built 4-input NAND sum-of-products circuits.
- Holds an arbitrary N-input Boolean function as a programmable 2^N-bit minterm mask.
- On command, sweeps all input vectors 0..2^N-1 in ascending order, one per accepted beat, over a valid/ready stream.
- Reports the count of true minterms when the sweep ends.
- Used as the automated truth-table generator and checker for the gate-level exercises.

---
 rtl/tts_pkg.sv | 17 +
 rtl/truth_table_scanner_sop_lookup.sv | 22 ++
 rtl/truth_table_scanner.sv | 162 ++++++++++++++++
 tb/tb_truth_table_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table scanner (state encoding, mask sizing).
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tts_state_e;

    // Reset value of every bit of the programmable minterm mask.
    localparam logic TTS_RESET_MASK_BIT = 1'b0;

    function automatic int tts_mask_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_sop_lookup.sv
// Combinational M:1 minterm mux: returns mask_i[idx_i] as a one-hot AND-OR tree.
module sop_lookup
    import tts_pkg::*;
#(
    parameter  int N = 4,
    localparam int M = tts_mask_width(N)
) (
    input  logic [M-1:0] mask_i,
    input  logic [N-1:0] idx_i,
    output logic         bit_o
);

    logic [M-1:0] term;

    // Each minterm contributes only when its index is selected, mirroring a sum of products.
    for (genvar gi = 0; gi < M; gi++) begin : g_term
        assign term[gi] = mask_i[gi] && (int'(idx_i) == gi);
    end

    assign bit_o = |term;

endmodule

// File: rtl/truth_table_scanner.sv
// Programmable N-input truth-table sweeper over a valid/ready stream.
// Optional expected-mask checker is enabled with the TTS_CHECK_EN macro.
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter  int N = 4,
    localparam int M = tts_mask_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [M-1:0] mask_in,
    input  logic         start,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_vec,
    output logic         out_s,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
`ifdef TTS_CHECK_EN
    ,
    input  logic [M-1:0] exp_mask,
    output logic [N:0]   mismatch_count,
    output logic [N-1:0] first_miss,
    output logic         miss_seen
`endif
);

    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    tts_state_e   state_q, state_d;
    logic [M-1:0] mask_q, mask_d;
    logic [N-1:0] idx_q, idx_d;
    logic         out_s_q, out_s_d;
    logic [N:0]   ones_q, ones_d;
    logic         refresh_s;
    logic         lookup_bit;
    logic         start_go;
    logic         accept;

    assign start_go = (state_q == IDLE) && start;
    assign accept   = (state_q == RUN) && out_ready;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        ones_d    = ones_q;
        refresh_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    mask_d = mask_in;
                end
                if (start) begin
                    state_d   = RUN;
                    idx_d     = '0;
                    ones_d    = '0;
                    refresh_s = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    ones_d = ones_q + {{N{1'b0}}, out_s_q};
                end
                // Abort beats completion, but a beat accepted alongside it still counts.
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        refresh_s = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Looking up with the next mask/index lets a same-cycle load feed the first beat.
    sop_lookup #(.N(N)) u_lookup (
        .mask_i (mask_d),
        .idx_i  (idx_d),
        .bit_o  (lookup_bit)
    );

    assign out_s_d = refresh_s ? lookup_bit : out_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= {M{TTS_RESET_MASK_BIT}};
            idx_q   <= '0;
            out_s_q <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            out_s_q <= out_s_d;
            ones_q  <= ones_d;
        end
    end

    assign out_valid  = (state_q == RUN);
    assign out_vec    = idx_q;
    assign out_s      = out_s_q;
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign done       = (state_q == DONE);
    assign ones_count = ones_q;

`ifdef TTS_CHECK_EN
    logic         exp_bit;
    logic         miss;
    logic [N:0]   mismatch_q;
    logic [N-1:0] first_miss_q;
    logic         miss_seen_q;

    sop_lookup #(.N(N)) u_exp_lookup (
        .mask_i (exp_mask),
        .idx_i  (idx_q),
        .bit_o  (exp_bit)
    );

    assign miss = accept && (out_s_q != exp_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q   <= '0;
            first_miss_q <= '0;
            miss_seen_q  <= 1'b0;
        end else if (start_go) begin
            mismatch_q   <= '0;
            first_miss_q <= '0;
            miss_seen_q  <= 1'b0;
        end else if (miss) begin
            mismatch_q <= mismatch_q + 1'b1;
            if (!miss_seen_q) begin
                first_miss_q <= idx_q;
                miss_seen_q  <= 1'b1;
            end
        end
    end

    assign mismatch_count = mismatch_q;
    assign first_miss     = first_miss_q;
    assign miss_seen      = miss_seen_q;
`else
    logic unused_start_go;
    assign unused_start_go = start_go;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized and directed self-checking bench for truth_table_scanner (N=4 and N=1 instances).
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N = 4 instance
    logic        load = 0, start = 0, abort = 0, out_ready = 0;
    logic [15:0] mask_in = '0;
    logic        out_valid, out_s, busy, done;
    logic [3:0]  out_vec;
    logic [4:0]  ones_count;

    // N = 1 instance
    logic        load1 = 0, start1 = 0, abort1 = 0, ready1 = 0;
    logic [1:0]  mask1 = '0;
    logic        valid1, s1, busy1, done1;
    logic [0:0]  vec1;
    logic [1:0]  ones1;

`ifdef TTS_CHECK_EN
    logic [15:0] exp_mask = 16'h7310;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_miss;
    logic        miss_seen;
    logic [1:0]  exp1 = 2'b10;
    logic [1:0]  mm1;
    logic [0:0]  fm1;
    logic        ms1;
`endif

    truth_table_scanner #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .mask_in(mask_in), .start(start),
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_s(out_s), .busy(busy), .done(done), .ones_count(ones_count)
`ifdef TTS_CHECK_EN
        , .exp_mask(exp_mask), .mismatch_count(mismatch_count),
        .first_miss(first_miss), .miss_seen(miss_seen)
`endif
    );

    truth_table_scanner #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .mask_in(mask1), .start(start1),
        .abort(abort1), .out_valid(valid1), .out_ready(ready1), .out_vec(vec1),
        .out_s(s1), .busy(busy1), .done(done1), .ones_count(ones1)
`ifdef TTS_CHECK_EN
        , .exp_mask(exp1), .mismatch_count(mm1), .first_miss(fm1), .miss_seen(ms1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] cur_mask = '0;   // model of the DUT mask register

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ones_below(input logic [15:0] m, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(m[i]);
        return c;
    endfunction

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic sweep(input string tag, input logic [15:0] m, input bit do_load, input int mode);
        int exp_vec = 0;
        int cyc = 0;
        if (do_load) begin
            load = 1; mask_in = m; cur_mask = m;
        end
        start = 1;
        tick();
        load = 0; start = 0;
        chk({tag, ".clr"}, ones_count, 0);
`ifdef TTS_CHECK_EN
        chk({tag, ".mmclr"}, mismatch_count, 0);
        chk({tag, ".msclr"}, miss_seen, 0);
`endif
        while (exp_vec < 16 && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            chk({tag, ".valid"}, out_valid, 1);
            chk({tag, ".vec"}, out_vec, exp_vec);
            chk({tag, ".s"}, out_s, cur_mask[exp_vec]);
            chk({tag, ".run_ones"}, ones_count, ones_below(cur_mask, exp_vec));
            if (out_ready) exp_vec++;
            cyc++;
            tick();
        end
        out_ready = 0;
        chk({tag, ".no_timeout"}, cyc < 400, 1);
        if (mode == 0) chk({tag, ".latency"}, cyc, 16);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".done_valid"}, out_valid, 0);
        chk({tag, ".done_busy"}, busy, 1);
        chk({tag, ".ones"}, ones_count, $countones(cur_mask));
`ifdef TTS_CHECK_EN
        begin
            logic [15:0] diff;
            int first;
            diff = cur_mask ^ exp_mask;
            first = 0;
            for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
            chk({tag, ".mm"}, mismatch_count, $countones(diff));
            chk({tag, ".seen"}, miss_seen, (diff != 0));
            if (diff != 0) chk({tag, ".first"}, first_miss, first);
        end
`endif
        tick();
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".hold_ones"}, ones_count, $countones(cur_mask));
    endtask

    initial begin
        int cyc;
        // Reset state
        tick();
        chk("rst.valid", out_valid, 0);
        chk("rst.vec", out_vec, 0);
        chk("rst.s", out_s, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ones", ones_count, 0);
        rst_n = 1;
        tick();

        // Reference function, steady drain and with backpressure
        sweep("ref", 16'h7310, 1, 0);
        sweep("bp", 16'h7310, 1, 1);
        sweep("zero", 16'h0000, 1, 0);
        sweep("full", 16'hFFFF, 1, 2);
        for (int r = 0; r < 4; r++) sweep("rnd", 16'($urandom), 1, 2);

        // Abort at vec 5 while start/load are issued mid-run
        load = 1; mask_in = 16'h7310; cur_mask = 16'h7310; start = 1;
        tick();
        load = 0; start = 0; out_ready = 1;
        cyc = 0;
        while (out_vec != 4'd5 && cyc < 50) begin
            if (cyc == 2) begin
                start = 1; load = 1; mask_in = 16'hFFFF;
            end else begin
                start = 0; load = 0;
            end
            tick();
            cyc++;
        end
        start = 0; load = 0;
        chk("abort.reach", out_vec, 5);
        abort = 1;
        tick();
        abort = 0; out_ready = 0;
        chk("abort.valid", out_valid, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.ones", ones_count, $countones(cur_mask & 16'h003F));
        abort = 1;
        tick();
        abort = 0;
        chk("abort.nodone", done, 0);
        chk("abort.idle_abort", busy, 0);
        chk("abort.keep_ones", ones_count, $countones(cur_mask & 16'h003F));
        sweep("reuse", 16'h0000, 0, 0);

        // Asynchronous reset mid-sweep at vec 7
        load = 1; mask_in = 16'hFFFF; cur_mask = 16'hFFFF; start = 1;
        tick();
        load = 0; start = 0; out_ready = 1;
        cyc = 0;
        while (out_vec != 4'd7 && cyc < 50) begin
            tick();
            cyc++;
        end
        out_ready = 0;
        chk("arst.reach", out_vec, 7);
        #2 rst_n = 0;
        cur_mask = '0;
        #1;
        chk("arst.valid", out_valid, 0);
        chk("arst.vec", out_vec, 0);
        chk("arst.s", out_s, 0);
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.ones", ones_count, 0);
        #2 rst_n = 1;
        tick();
        chk("arst.idle", busy, 0);
        chk("arst.nodone", done, 0);
        sweep("postrst", 16'h0000, 0, 2);

`ifdef TTS_CHECK_EN
        sweep("chk", 16'h7311, 1, 0);
        chk("chk.mm_fixed", mismatch_count, 1);
        chk("chk.first_fixed", first_miss, 0);
        chk("chk.seen_fixed", miss_seen, 1);
`endif

        // N = 1 instance, mask 2'b10
        load1 = 1; mask1 = 2'b10; start1 = 1;
        tick();
        load1 = 0; start1 = 0; ready1 = 1;
        chk("n1.valid0", valid1, 1);
        chk("n1.vec0", vec1, 0);
        chk("n1.s0", s1, 0);
        tick();
        chk("n1.valid1", valid1, 1);
        chk("n1.vec1", vec1, 1);
        chk("n1.s1", s1, 1);
        tick();
        ready1 = 0;
        chk("n1.done", done1, 1);
        chk("n1.ones", ones1, 1);
        chk("n1.done_valid", valid1, 0);
        tick();
        chk("n1.idle", busy1, 0);
        chk("n1.done_pulse", done1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
